comm_load_seq: RTL and testbench

COMM_LOAD_SEQ -- requirements
Module: comm_load_seq

---
 rtl/comm_load_seq.sv | 166 ++++++++++++++++
 tb/tb_comm_load_seq.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comm_load_seq.sv
// Host load sequencer: UART bytes to vector writes, multiply start,
// and result bytes back out through the UART transmitter.
module comm_load_seq #(
    parameter int TIMEOUT = 4096,
    parameter int RES_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_data,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             mult_done,
    input  logic [RES_W-1:0] mult_result,
    input  logic             tx_busy,
    output logic             wr_en,
    output logic [1:0]       wr_sel,
    output logic [1:0]       wr_addr,
    output logic [15:0]      wr_data,
    output logic             mult_start,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic             done,
    output logic             error
);
    localparam int NBYTES = RES_W / 8;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, START, WAIT_MULT, SEND, WAIT_TX
    } state_t;

    state_t           state, state_n;
    logic [4:0]       cnt, cnt_n;
    logic [7:0]       lo, lo_n;
    logic [TW-1:0]    tmo, tmo_n;
    logic [RES_W-1:0] shreg, shreg_n;
    logic [BW-1:0]    bcnt, bcnt_n;
    logic             first, first_n;
    logic             err_n;
    logic             wr_en_n;
    logic [1:0]       wr_sel_n, wr_addr_n;
    logic [15:0]      wr_data_n;
    logic             last_wr;

    // The 16th write is on the bus; the counter has already wrapped.
    assign last_wr = wr_en && (wr_sel == 2'd3) && (wr_addr == 2'd3);
    assign tx_data = tx_start ? shreg[7:0] : 8'h00;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        lo_n       = lo;
        tmo_n      = tmo;
        shreg_n    = shreg;
        bcnt_n     = bcnt;
        first_n    = 1'b0;
        err_n      = error;
        wr_en_n    = 1'b0;
        wr_sel_n   = wr_sel;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        mult_start = 1'b0;
        tx_start   = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_data) state_n = LOAD;
            end
            LOAD: begin
                if (last_wr) begin
                    state_n = START;
                end else if (!load_data) begin
                    state_n = IDLE;
                    if (cnt != 5'd0) err_n = 1'b1;
                    cnt_n = 5'd0;
                    tmo_n = '0;
                end else if (rx_valid) begin
                    cnt_n = cnt + 5'd1;
                    tmo_n = '0;
                    if (cnt == 5'd0) err_n = 1'b0;
                    if (!cnt[0]) begin
                        lo_n = rx_data;
                    end else begin
                        wr_en_n   = 1'b1;
                        wr_sel_n  = cnt[4:3];
                        wr_addr_n = cnt[2:1];
                        wr_data_n = {rx_data, lo};
                    end
                end else if (cnt != 5'd0) begin
                    if (tmo >= TW'(TIMEOUT - 1)) begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                        cnt_n   = 5'd0;
                        tmo_n   = '0;
                    end else begin
                        tmo_n = tmo + 1'b1;
                    end
                end
            end
            START: begin
                mult_start = 1'b1;
                state_n    = WAIT_MULT;
            end
            WAIT_MULT: begin
                if (mult_done) begin
                    shreg_n = mult_result;
                    bcnt_n  = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    first_n  = 1'b1;
                    state_n  = WAIT_TX;
                end
            end
            WAIT_TX: begin
                // tx_busy may lag tx_start by a cycle, so skip the first look.
                if (!first && !tx_busy) begin
                    shreg_n = shreg >> 8;
                    if (bcnt == BW'(NBYTES - 1)) begin
                        done    = 1'b1;
                        bcnt_n  = '0;
                        state_n = IDLE;
                    end else begin
                        bcnt_n  = bcnt + 1'b1;
                        state_n = SEND;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            lo      <= 8'h00;
            tmo     <= '0;
            shreg   <= '0;
            bcnt    <= '0;
            first   <= 1'b0;
            error   <= 1'b0;
            wr_en   <= 1'b0;
            wr_sel  <= 2'd0;
            wr_addr <= 2'd0;
            wr_data <= 16'h0000;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            lo      <= lo_n;
            tmo     <= tmo_n;
            shreg   <= shreg_n;
            bcnt    <= bcnt_n;
            first   <= first_n;
            error   <= err_n;
            wr_en   <= wr_en_n;
            wr_sel  <= wr_sel_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
        end
    end
endmodule

// File: tb/tb_comm_load_seq.sv
// Directed bench for comm_load_seq: loads, result send, aborts
// and mid-operation reset.
module tb_comm_load_seq;
    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_data;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        mult_done;
    logic [31:0] mult_result;
    logic        tx_busy;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        mult_start;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        done;
    logic        error;

    int compared = 0;
    int mismatched = 0;
    int wr_cnt = 0;
    int ms_cnt = 0;
    int tx_cnt = 0;
    int done_cnt = 0;
    logic [1:0]  log_sel [128];
    logic [1:0]  log_addr [128];
    logic [15:0] log_data [128];
    logic [7:0]  tx_log [64];
    logic [7:0]  ld [32];

    always #5 clk = ~clk;

    comm_load_seq #(.TIMEOUT(TMO), .RES_W(32)) dut (
        .clk(clk), .reset(reset), .load_data(load_data),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .mult_done(mult_done), .mult_result(mult_result),
        .tx_busy(tx_busy), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .mult_start(mult_start), .tx_start(tx_start),
        .tx_data(tx_data), .done(done), .error(error)
    );

    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_cnt < 128) begin
                log_sel[wr_cnt]  <= wr_sel;
                log_addr[wr_cnt] <= wr_addr;
                log_data[wr_cnt] <= wr_data;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (mult_start) ms_cnt <= ms_cnt + 1;
        if (tx_start) begin
            if (tx_cnt < 64) tx_log[tx_cnt] <= tx_data;
            tx_cnt <= tx_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick;
        rx_valid = 1'b0;
    endtask

    task automatic load_and_check;
        int w0, m0, k;
        logic [15:0] exp_d;
        w0 = wr_cnt;
        m0 = ms_cnt;
        load_data = 1'b1;
        tick;
        send_byte(ld[0]);
        compared++;
        if (error !== 1'b0) begin
            mismatched++;
            $display("FAIL err_clear got=%0b want=0", error);
        end
        for (int i = 1; i < 32; i++) send_byte(ld[i]);
        load_data = 1'b0;
        compared++;
        if (ms_cnt !== m0) begin
            mismatched++;
            $display("FAIL early_start got=%0d want=%0d", ms_cnt, m0);
        end
        tick;
        tick;
        compared++;
        if (wr_cnt - w0 !== 16) begin
            mismatched++;
            $display("FAIL wr_count got=%0d want=16", wr_cnt - w0);
        end
        compared++;
        if (ms_cnt - m0 !== 1) begin
            mismatched++;
            $display("FAIL start_count got=%0d want=1", ms_cnt - m0);
        end
        for (int j = 0; j < 16; j++) begin
            k = w0 + j;
            exp_d = {ld[2*j+1], ld[2*j]};
            compared++;
            if (log_sel[k] !== 2'(j / 4) || log_addr[k] !== 2'(j % 4) ||
                log_data[k] !== exp_d) begin
                mismatched++;
                $display("FAIL wr%0d got=%0d/%0d/%h want=%0d/%0d/%h", j,
                         log_sel[k], log_addr[k], log_data[k],
                         j / 4, j % 4, exp_d);
            end
        end
    endtask

    task automatic run_send(input logic [31:0] res);
        int t0, d0, seen, busy_left;
        t0 = tx_cnt;
        d0 = done_cnt;
        seen = t0;
        busy_left = 0;
        mult_result = res;
        mult_done = 1'b1;
        tick;
        mult_done = 1'b0;
        for (int c = 0; c < 600 && done_cnt == d0; c++) begin
            tick;
            if (tx_cnt > seen) begin
                seen = tx_cnt;
                tx_busy = 1'b1;
                busy_left = 10;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) tx_busy = 1'b0;
            end
        end
        tx_busy = 1'b0;
        compared++;
        if (done_cnt - d0 !== 1) begin
            mismatched++;
            $display("FAIL done_pulse got=%0d want=1", done_cnt - d0);
        end
        compared++;
        if (tx_cnt - t0 !== 4) begin
            mismatched++;
            $display("FAIL tx_count got=%0d want=4", tx_cnt - t0);
        end
        for (int b = 0; b < 4; b++) begin
            compared++;
            if (tx_log[t0+b] !== res[8*b +: 8]) begin
                mismatched++;
                $display("FAIL tx_byte%0d got=%h want=%h", b,
                         tx_log[t0+b], res[8*b +: 8]);
            end
        end
        mult_result = 32'h0;
        repeat (20) tick;
        compared++;
        if (tx_cnt - t0 !== 4 || done_cnt - d0 !== 1) begin
            mismatched++;
            $display("FAIL idle_after_done got=%0d/%0d want=4/1",
                     tx_cnt - t0, done_cnt - d0);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        load_data = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        mult_done = 1'b0;
        mult_result = 32'h0;
        tx_busy = 1'b0;
        repeat (3) tick;
        compared++;
        if ({wr_en, wr_sel, wr_addr, wr_data, mult_start, tx_start,
             tx_data, done, error} !== 34'h0) begin
            mismatched++;
            $display("FAIL reset_outs got=%b want=0",
                     {wr_en, wr_sel, wr_addr, wr_data, mult_start,
                      tx_start, tx_data, done, error});
        end
        reset = 1'b1;
        repeat (3) tick;
        compared++;
        if (error !== 1'b0 || wr_cnt !== 0 || ms_cnt !== 0) begin
            mismatched++;
            $display("FAIL post_reset got=%0b/%0d/%0d want=0/0/0",
                     error, wr_cnt, ms_cnt);
        end
    endtask

    task automatic test_full_load;
        int w0, w1, m1;
        w0 = wr_cnt;
        load_and_check;
        compared++;
        if (log_data[w0] !== 16'hFFFF || log_sel[w0] !== 2'd0) begin
            mismatched++;
            $display("FAIL hand_w0 got=%h want=FFFF", log_data[w0]);
        end
        compared++;
        if (log_data[w0+4] !== 16'h0000 || log_sel[w0+4] !== 2'd1 ||
            log_addr[w0+4] !== 2'd0) begin
            mismatched++;
            $display("FAIL hand_w4 got=%h want=0000", log_data[w0+4]);
        end
        compared++;
        if (log_data[w0+5] !== 16'h0001 || log_addr[w0+5] !== 2'd1) begin
            mismatched++;
            $display("FAIL hand_w5 got=%h want=0001", log_data[w0+5]);
        end
        compared++;
        if (log_data[w0+8] !== 16'hEEEE || log_data[w0+12] !== 16'h0003) begin
            mismatched++;
            $display("FAIL hand_w8_w12 got=%h/%h want=EEEE/0003",
                     log_data[w0+8], log_data[w0+12]);
        end
        w1 = wr_cnt;
        m1 = ms_cnt;
        send_byte(8'h5A);
        send_byte(8'hA5);
        send_byte(8'h3C);
        tick;
        compared++;
        if (wr_cnt !== w1 || ms_cnt !== m1) begin
            mismatched++;
            $display("FAIL wait_mult_rx got=%0d/%0d want=%0d/%0d",
                     wr_cnt, ms_cnt, w1, m1);
        end
    endtask

    task automatic test_timeout;
        int w0, m0;
        w0 = wr_cnt;
        m0 = ms_cnt;
        load_data = 1'b1;
        tick;
        for (int i = 0; i < 5; i++) send_byte(ld[i]);
        repeat (TMO - 1) tick;
        compared++;
        if (error !== 1'b0) begin
            mismatched++;
            $display("FAIL tmo_early got=%0b want=0", error);
        end
        tick;
        compared++;
        if (error !== 1'b1) begin
            mismatched++;
            $display("FAIL tmo_err got=%0b want=1", error);
        end
        load_data = 1'b0;
        repeat (3) tick;
        compared++;
        if (wr_cnt - w0 !== 2 || ms_cnt !== m0) begin
            mismatched++;
            $display("FAIL tmo_writes got=%0d/%0d want=2/0",
                     wr_cnt - w0, ms_cnt - m0);
        end
        compared++;
        if (error !== 1'b1) begin
            mismatched++;
            $display("FAIL err_sticky got=%0b want=1", error);
        end
        load_and_check;
        run_send(32'hA5C30F96);
    endtask

    task automatic test_abort;
        int w0, m0;
        w0 = wr_cnt;
        m0 = ms_cnt;
        load_data = 1'b1;
        tick;
        for (int i = 0; i < 9; i++) send_byte(ld[i]);
        rx_valid = 1'b1;
        rx_data = ld[9];
        load_data = 1'b0;
        tick;
        rx_valid = 1'b0;
        repeat (3) tick;
        compared++;
        if (error !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_err got=%0b want=1", error);
        end
        compared++;
        if (wr_cnt - w0 !== 4 || ms_cnt !== m0) begin
            mismatched++;
            $display("FAIL abort_writes got=%0d/%0d want=4/0",
                     wr_cnt - w0, ms_cnt - m0);
        end
    endtask

    task automatic test_reset_mid;
        int t0, w0, m0, d0;
        load_and_check;
        t0 = tx_cnt;
        mult_result = 32'hDEADBEEF;
        mult_done = 1'b1;
        tick;
        mult_done = 1'b0;
        for (int c = 0; c < 20 && tx_cnt == t0; c++) tick;
        compared++;
        if (tx_cnt - t0 !== 1) begin
            mismatched++;
            $display("FAIL mid_first_tx got=%0d want=1", tx_cnt - t0);
        end
        tx_busy = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        compared++;
        if ({wr_en, wr_sel, wr_addr, wr_data, mult_start, tx_start,
             tx_data, done, error} !== 34'h0) begin
            mismatched++;
            $display("FAIL mid_reset_outs got=%b want=0",
                     {wr_en, wr_sel, wr_addr, wr_data, mult_start,
                      tx_start, tx_data, done, error});
        end
        tx_busy = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        t0 = tx_cnt;
        w0 = wr_cnt;
        m0 = ms_cnt;
        d0 = done_cnt;
        repeat (50) tick;
        compared++;
        if (tx_cnt !== t0 || done_cnt !== d0 || wr_cnt !== w0 ||
            ms_cnt !== m0) begin
            mismatched++;
            $display("FAIL post_mid_reset got=%0d/%0d/%0d/%0d want=0/0/0/0",
                     tx_cnt - t0, done_cnt - d0, wr_cnt - w0, ms_cnt - m0);
        end
    endtask

    initial begin
        for (int e = 0; e < 4; e++) begin
            ld[2*e]      = 8'hFF;
            ld[2*e+1]    = 8'hFF;
            ld[8+2*e]    = 8'(e);
            ld[8+2*e+1]  = 8'h00;
            ld[16+2*e]   = 8'hEE;
            ld[16+2*e+1] = 8'hEE;
            ld[24+2*e]   = 8'(3 - e);
            ld[24+2*e+1] = 8'h00;
        end
        test_reset;
        test_full_load;
        run_send(32'h11223344);
        test_timeout;
        test_abort;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
